// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA ring scheduler.
// Counter arithmetic is modular in CNT_W bits.
package dma_pkg;

    localparam int ADR_W = 28;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_GAP,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    function automatic logic [CNT_W-1:0] cnt_diff(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        return a - b;
    endfunction

endpackage

// File: rtl/dma_ring_sched.sv
// Walks a ring of SDRAM buffers, issuing line DMA commands
// while respecting DMA slots and software buffer releases.
module dma_ring_sched
    import dma_pkg::*;
#(
    parameter int DMA_SLOTS = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             MODE_CYCLIC,
    input  logic [ADR_W-1:0] RING_BASE,
    input  logic [ADR_W-1:0] BUF_SIZE,
    input  logic [CNT_W-1:0] RING_BUFS,
    input  logic [CNT_W-1:0] SW_REL_CNT,
    input  logic [CNT_W-1:0] DMA_DONE_CNT,
    input  logic             FIFO_AFULL,
    output logic             DMA_START,
    output logic [ADR_W-1:0] DMA_START_ADR,
    output logic [ADR_W-1:0] DMA_BUF_SIZE,
    output logic [CNT_W-1:0] WR_IDX,
    output logic [CNT_W-1:0] FILLED_CNT,
    output logic             RING_FULL,
    output logic             OVERRUN,
    output logic             ERR,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] SLOTS = CNT_W'(DMA_SLOTS);

    sched_state_t     state;
    logic [ADR_W-1:0] base_q;
    logic [ADR_W-1:0] size_q;
    logic [ADR_W-1:0] adr_next;
    logic [CNT_W-1:0] bufs_q;
    logic [CNT_W-1:0] done_base;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] idx_next;
    logic             cyclic_q;
    logic             run_q;

    logic [CNT_W-1:0] done;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] free;
    logic             slot_ok;
    logic             free_ok;
    logic             drained;
    logic             last_buf;
    logic             chk_err;

    assign done        = cnt_diff(DMA_DONE_CNT, done_base);
    assign outstanding = cnt_diff(issued, done);
    assign free        = cnt_diff(bufs_q, cnt_diff(issued, SW_REL_CNT));

    // Negative distances (done ahead of issue) must not block issuing.
    assign slot_ok  = outstanding[CNT_W-1] || (outstanding < SLOTS);
    assign free_ok  = !free[CNT_W-1] && (free != '0);
    assign drained  = outstanding[CNT_W-1] || (outstanding == '0);
    assign last_buf = !cyclic_q && (issued == bufs_q);
    assign chk_err  = (state != S_IDLE) && (state != S_LOAD);

    assign RING_FULL  = (state == S_ISSUE) && (free == '0) && EN;
    assign FILLED_CNT = run_q ? done : '0;
    assign BUSY       = (state != S_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            base_q        <= '0;
            size_q        <= '0;
            adr_next      <= '0;
            bufs_q        <= '0;
            done_base     <= '0;
            issued        <= '0;
            idx_next      <= '0;
            cyclic_q      <= 1'b0;
            run_q         <= 1'b0;
            DMA_START     <= 1'b0;
            DMA_START_ADR <= '0;
            DMA_BUF_SIZE  <= '0;
            WR_IDX        <= '0;
            OVERRUN       <= 1'b0;
            ERR           <= 1'b0;
        end else begin
            DMA_START <= 1'b0;
            if (RING_FULL && FIFO_AFULL)
                OVERRUN <= 1'b1;
            if (chk_err && (outstanding > SLOTS))
                ERR <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (EN)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    base_q    <= RING_BASE;
                    size_q    <= BUF_SIZE;
                    bufs_q    <= RING_BUFS;
                    cyclic_q  <= MODE_CYCLIC;
                    done_base <= DMA_DONE_CNT;
                    issued    <= '0;
                    adr_next  <= '0;
                    idx_next  <= '0;
                    run_q     <= 1'b1;
                    OVERRUN   <= 1'b0;
                    ERR       <= 1'b0;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!EN || last_buf) begin
                        state <= S_DRAIN;
                    end else if (slot_ok && free_ok) begin
                        DMA_START     <= 1'b1;
                        DMA_START_ADR <= base_q + adr_next;
                        DMA_BUF_SIZE  <= size_q;
                        WR_IDX        <= idx_next;
                        issued        <= issued + 1'b1;
                        if (idx_next == bufs_q - 1'b1) begin
                            idx_next <= '0;
                            adr_next <= '0;
                        end else begin
                            idx_next <= idx_next + 1'b1;
                            adr_next <= adr_next + size_q;
                        end
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_ISSUE;
                end
                S_DRAIN: begin
                    if (drained)
                        state <= last_buf ? S_DONE : S_IDLE;
                end
                S_DONE: begin
                    if (!EN)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_ring_sched.sv
// Directed bench for dma_ring_sched with a fixed-latency DMA model.
// Each command completes 50 cycles after its strobe.
module tb_dma_ring_sched;
    import dma_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic             EN;
    logic             MODE_CYCLIC;
    logic [ADR_W-1:0] RING_BASE;
    logic [ADR_W-1:0] BUF_SIZE;
    logic [CNT_W-1:0] RING_BUFS;
    wire  [CNT_W-1:0] SW_REL_CNT;
    wire  [CNT_W-1:0] DMA_DONE_CNT;
    logic             FIFO_AFULL;
    logic             DMA_START;
    logic [ADR_W-1:0] DMA_START_ADR;
    logic [ADR_W-1:0] DMA_BUF_SIZE;
    logic [CNT_W-1:0] WR_IDX;
    logic [CNT_W-1:0] FILLED_CNT;
    logic             RING_FULL;
    logic             OVERRUN;
    logic             ERR;
    logic             BUSY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dma_ring_sched dut (
        .CLK          (CLK),
        .RST          (RST),
        .EN           (EN),
        .MODE_CYCLIC  (MODE_CYCLIC),
        .RING_BASE    (RING_BASE),
        .BUF_SIZE     (BUF_SIZE),
        .RING_BUFS    (RING_BUFS),
        .SW_REL_CNT   (SW_REL_CNT),
        .DMA_DONE_CNT (DMA_DONE_CNT),
        .FIFO_AFULL   (FIFO_AFULL),
        .DMA_START    (DMA_START),
        .DMA_START_ADR(DMA_START_ADR),
        .DMA_BUF_SIZE (DMA_BUF_SIZE),
        .WR_IDX       (WR_IDX),
        .FILLED_CNT   (FILLED_CNT),
        .RING_FULL    (RING_FULL),
        .OVERRUN      (OVERRUN),
        .ERR          (ERR),
        .BUSY         (BUSY)
    );

    // DMA engine and software-release model
    logic [CNT_W-1:0] done_ctr = '0;
    logic [CNT_W-1:0] done_seed = '0;
    logic [CNT_W-1:0] sw_off = '0;
    logic [CNT_W-1:0] sw_manual = '0;
    bit               sw_track = 1'b1;
    int               pend[$];
    int               strobe_cnt = 0;
    int               max_out = 0;
    logic [ADR_W-1:0] adr_log[$];
    logic [CNT_W-1:0] idx_log[$];

    assign DMA_DONE_CNT = done_seed + done_ctr;
    assign SW_REL_CNT   = sw_track ? (done_ctr - sw_off) : sw_manual;

    always @(negedge CLK) begin
        for (int i = 0; i < pend.size(); i++)
            pend[i] = pend[i] - 1;
        while (pend.size() > 0 && pend[0] <= 0) begin
            void'(pend.pop_front());
            done_ctr = done_ctr + 1'b1;
        end
        if (DMA_START === 1'b1) begin
            pend.push_back(50);
            strobe_cnt++;
            adr_log.push_back(DMA_START_ADR);
            idx_log.push_back(WR_IDX);
        end
        if (pend.size() > max_out)
            max_out = pend.size();
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic wait_strobes(input int target, input int budget,
                                input string name);
        int k = 0;
        while (strobe_cnt < target && k < budget) begin
            @(negedge CLK);
            #1;
            k++;
        end
        checks++;
        if (strobe_cnt < target) begin
            errors++;
            $display("FAIL %s: strobes %0d required %0d",
                     name, strobe_cnt, target);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (BUSY !== 1'b0 && k < budget) begin
            @(negedge CLK);
            #1;
            k++;
        end
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s: BUSY %b required 0", name, BUSY);
        end
    endtask

    task automatic start_run(input logic [ADR_W-1:0] base,
                             input logic [ADR_W-1:0] size,
                             input logic [CNT_W-1:0] bufs,
                             input logic cyc);
        RING_BASE   = base;
        BUF_SIZE    = size;
        RING_BUFS   = bufs;
        MODE_CYCLIC = cyc;
        sw_off      = done_ctr;
        EN          = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        wait_cycles(3);
        checks++;
        if ({DMA_START, RING_FULL, OVERRUN, ERR, BUSY} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {DMA_START, RING_FULL, OVERRUN, ERR, BUSY});
        end
        checks++;
        if (DMA_START_ADR !== '0 || DMA_BUF_SIZE !== '0) begin
            errors++;
            $display("FAIL reset_cmd: adr %h size %h required 0 0",
                     DMA_START_ADR, DMA_BUF_SIZE);
        end
        checks++;
        if (WR_IDX !== '0 || FILLED_CNT !== '0) begin
            errors++;
            $display("FAIL reset_cnt: idx %0d filled %0d required 0 0",
                     WR_IDX, FILLED_CNT);
        end
        RST = 1'b0;
        wait_cycles(2);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_en0: BUSY %b required 0", BUSY);
        end
    endtask

    task automatic test_cyclic();
        logic [ADR_W-1:0] ea[5];
        logic [CNT_W-1:0] ei[5];
        int s0;
        ea = '{28'h100, 28'h4CC, 28'h898, 28'hC64, 28'h100};
        ei = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
        s0 = strobe_cnt;
        start_run(28'h100, 28'd972, 16'd4, 1'b1);
        wait_cycles(1);
        checks++;
        if (BUSY !== 1'b1 || DMA_START !== 1'b0) begin
            errors++;
            $display("FAIL lat_load: busy %b start %b required 1 0",
                     BUSY, DMA_START);
        end
        wait_cycles(1);
        checks++;
        if (DMA_START !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: start %b required 0", DMA_START);
        end
        wait_cycles(1);
        checks++;
        if (DMA_START !== 1'b1) begin
            errors++;
            $display("FAIL lat_strobe: start %b required 1", DMA_START);
        end
        wait_strobes(s0 + 5, 1000, "cyc_strobes");
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (adr_log[s0+i] !== ea[i] || idx_log[s0+i] !== ei[i]) begin
                errors++;
                $display("FAIL cyc_seq%0d: adr %h idx %0d required %h %0d",
                         i, adr_log[s0+i], idx_log[s0+i], ea[i], ei[i]);
            end
        end
        checks++;
        if (DMA_BUF_SIZE !== 28'd972) begin
            errors++;
            $display("FAIL cyc_size: %0d required 972", DMA_BUF_SIZE);
        end
        checks++;
        if (max_out > 2) begin
            errors++;
            $display("FAIL cyc_slots: max outstanding %0d required <=2",
                     max_out);
        end
        wait_idle(300, "cyc_idle");
        wait_cycles(1);
        checks++;
        if (FILLED_CNT !== 16'd5 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL cyc_filled: filled %0d err %b required 5 0",
                     FILLED_CNT, ERR);
        end
    endtask

    task automatic test_noncyclic();
        int s0 = strobe_cnt;
        start_run(28'h4000, 28'h200, 16'd3, 1'b0);
        wait_cycles(300);
        checks++;
        if (strobe_cnt - s0 != 3) begin
            errors++;
            $display("FAIL nc_count: strobes %0d required 3",
                     strobe_cnt - s0);
        end
        checks++;
        if (adr_log[$] !== 28'h4400) begin
            errors++;
            $display("FAIL nc_last: adr %h required 4400", adr_log[$]);
        end
        checks++;
        if (BUSY !== 1'b1 || FILLED_CNT !== 16'd3) begin
            errors++;
            $display("FAIL nc_done: busy %b filled %0d required 1 3",
                     BUSY, FILLED_CNT);
        end
        EN = 1'b0;
        wait_cycles(2);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL nc_exit: BUSY %b required 0", BUSY);
        end
    endtask

    task automatic test_ring_full();
        int s0 = strobe_cnt;
        sw_track  = 1'b0;
        sw_manual = '0;
        start_run(28'h2000, 28'h40, 16'd2, 1'b1);
        wait_cycles(100);
        checks++;
        if (strobe_cnt - s0 != 2 || RING_FULL !== 1'b1) begin
            errors++;
            $display("FAIL rf_stall: strobes %0d full %b required 2 1",
                     strobe_cnt - s0, RING_FULL);
        end
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL rf_no_ovr: OVERRUN %b required 0", OVERRUN);
        end
        FIFO_AFULL = 1'b1;
        wait_cycles(1);
        FIFO_AFULL = 1'b0;
        checks++;
        if (OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL rf_ovr: OVERRUN %b required 1", OVERRUN);
        end
        sw_manual = 16'd1;
        wait_strobes(s0 + 3, 20, "rf_release");
        checks++;
        if (adr_log[$] !== 28'h2000 || idx_log[$] !== 16'd0) begin
            errors++;
            $display("FAIL rf_wrap: adr %h idx %0d required 2000 0",
                     adr_log[$], idx_log[$]);
        end
        checks++;
        if (RING_FULL !== 1'b0 || OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL rf_sticky: full %b ovr %b required 0 1",
                     RING_FULL, OVERRUN);
        end
        wait_cycles(100);
        checks++;
        if (strobe_cnt - s0 != 3 || RING_FULL !== 1'b1) begin
            errors++;
            $display("FAIL rf_one_more: strobes %0d full %b required 3 1",
                     strobe_cnt - s0, RING_FULL);
        end
        EN = 1'b0;
        wait_idle(100, "rf_idle");
        sw_track = 1'b1;
    endtask

    task automatic test_wrap();
        int s0 = strobe_cnt;
        done_seed = 16'hFFFE - done_ctr;
        start_run(28'h8000, 28'h100, 16'd5, 1'b0);
        wait_cycles(400);
        checks++;
        if (strobe_cnt - s0 != 5) begin
            errors++;
            $display("FAIL wrap_count: strobes %0d required 5",
                     strobe_cnt - s0);
        end
        checks++;
        if (FILLED_CNT !== 16'd5 || ERR !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: filled %0d err %b busy %b req 5 0 1",
                     FILLED_CNT, ERR, BUSY);
        end
        EN = 1'b0;
        wait_idle(10, "wrap_idle");
    endtask

    task automatic test_en_drop();
        int s0 = strobe_cnt;
        start_run(28'h100, 28'h10, 16'd4, 1'b1);
        wait_strobes(s0 + 2, 50, "drop_two");
        EN = 1'b0;
        wait_cycles(20);
        checks++;
        if (BUSY !== 1'b1 || FILLED_CNT !== 16'd0) begin
            errors++;
            $display("FAIL drop_drain: busy %b filled %0d required 1 0",
                     BUSY, FILLED_CNT);
        end
        wait_cycles(50);
        checks++;
        if (BUSY !== 1'b0 || FILLED_CNT !== 16'd2) begin
            errors++;
            $display("FAIL drop_idle: busy %b filled %0d required 0 2",
                     BUSY, FILLED_CNT);
        end
        checks++;
        if (strobe_cnt - s0 != 2) begin
            errors++;
            $display("FAIL drop_count: strobes %0d required 2",
                     strobe_cnt - s0);
        end
    endtask

    task automatic test_rst_mid();
        int s0 = strobe_cnt;
        int s1;
        start_run(28'h3000, 28'h10, 16'd4, 1'b1);
        wait_strobes(s0 + 2, 50, "rst_pre");
        wait_cycles(5);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (BUSY !== 1'b0 || DMA_START_ADR !== '0 || WR_IDX !== '0) begin
            errors++;
            $display("FAIL rst_async: busy %b adr %h idx %0d required 0 0 0",
                     BUSY, DMA_START_ADR, WR_IDX);
        end
        checks++;
        if (DMA_BUF_SIZE !== '0 || FILLED_CNT !== '0) begin
            errors++;
            $display("FAIL rst_cnt: size %h filled %0d required 0 0",
                     DMA_BUF_SIZE, FILLED_CNT);
        end
        wait_cycles(70);
        sw_off = done_ctr;
        s1 = strobe_cnt;
        RST = 1'b0;
        wait_strobes(s1 + 1, 10, "rst_restart");
        checks++;
        if (adr_log[s1] !== 28'h3000 || idx_log[s1] !== 16'd0) begin
            errors++;
            $display("FAIL rst_first: adr %h idx %0d required 3000 0",
                     adr_log[s1], idx_log[s1]);
        end
        EN = 1'b0;
        wait_idle(100, "rst_idle");
    endtask

    initial begin
        RST         = 1'b1;
        EN          = 1'b0;
        MODE_CYCLIC = 1'b0;
        RING_BASE   = '0;
        BUF_SIZE    = '0;
        RING_BUFS   = '0;
        FIFO_AFULL  = 1'b0;
        test_reset();
        test_cyclic();
        test_noncyclic();
        test_ring_full();
        test_wrap();
        test_en_drop();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
